// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte serialiser between the core and the byte-wide RAM.
//
// Three requesters share the RAM port: instruction fetch (4-byte reads), load
// buffer (1/2/4-byte loads, sign/zero extended) and commit stores (1/2/4-byte
// writes). Each requester has a one-deep pending latch; the FSM grants in fixed
// priority store > load > fetch and moves one byte per cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rdy                  global enable; low freezes all state and gates mem_wr
//   in_clear             misprediction flush (drops pending/active loads and fetches)
//   in_fetch_*           fetch request / out_fetch_* done pulse + instruction word
//   in_load_*            load request  / out_load_*  done pulse + extended data
//   in_store_*           store request / out_store_ce done pulse
//   mem_din/mem_dout     RAM read / write data byte
//   mem_a, mem_wr        RAM byte address and write strobe
//   io_buffer_full       UART buffer full; stalls writes into the I/O region
module mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int IO_MASK_HI = 17,
    parameter int IO_MASK_LO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_clear,
    input  logic              in_fetch_ce,
    input  logic [ADDR_W-1:0] in_fetch_addr,
    output logic              out_fetch_ce,
    output logic [31:0]       out_fetch_data,
    input  logic              in_load_ce,
    input  logic [ADDR_W-1:0] in_load_addr,
    input  logic [2:0]        in_load_size,
    input  logic              in_load_signed,
    output logic              out_load_ce,
    output logic [31:0]       out_load_data,
    input  logic              in_store_ce,
    input  logic [ADDR_W-1:0] in_store_addr,
    input  logic [2:0]        in_store_size,
    input  logic [31:0]       in_store_data,
    output logic              out_store_ce,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t state, next_state;

    // Pending request latches
    logic              fetch_pend, load_pend, store_pend;
    logic [ADDR_W-1:0] fetch_addr_q, load_addr_q, store_addr_q;
    logic [2:0]        load_size_q, store_size_q;
    logic              load_signed_q;
    logic [31:0]       store_data_q;

    // Active-access datapath
    logic [1:0]        cnt;
    logic [2:0]        cur_size;
    logic              owner_fetch;
    logic [2:0][7:0]   rbuf;
    logic              mem_wr_q;

    // Combinational helpers
    logic              load_live, fetch_live;
    logic              grant_store, grant_load, grant_fetch;
    logic              last_byte, io_stall, read_done, write_done;
    logic [1:0]        cnt_next;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       raw_word, read_word;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= next_state;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise unassigned paths would infer latches.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_store)                    next_state = WRITE;
                     else if (grant_load || grant_fetch) next_state = READ;
            READ:    if (in_clear || last_byte)          next_state = IDLE;
            WRITE:   if (write_done)                     next_state = IDLE;
            default:                                     next_state = IDLE;
        endcase
    end

    // ---------------- output / datapath decode ----------------
    always_comb begin
        // A flush at this edge kills load/fetch latches, so they cannot be granted.
        load_live   = load_pend  && !in_clear;
        fetch_live  = fetch_pend && !in_clear;
        grant_store = store_pend;
        grant_load  = !store_pend && load_live;
        grant_fetch = !store_pend && !load_live && fetch_live;

        last_byte   = ({1'b0, cnt} == (cur_size - 3'd1));
        io_stall    = (state == WRITE) && mem_a[IO_MASK_HI] && mem_a[IO_MASK_LO] && io_buffer_full;
        read_done   = (state == READ)  && last_byte && !in_clear;
        write_done  = (state == WRITE) && last_byte && !io_stall;
        cnt_next    = cnt + 2'd1;

        // Last byte comes straight from mem_din; lanes above it are zero.
        b0 = (cnt == 2'd0) ? mem_din : rbuf[0];
        b1 = (cnt == 2'd1) ? mem_din : ((cnt > 2'd1) ? rbuf[1] : 8'h00);
        b2 = (cnt == 2'd2) ? mem_din : ((cnt > 2'd2) ? rbuf[2] : 8'h00);
        b3 = (cnt == 2'd3) ? mem_din : 8'h00;
        raw_word = {b3, b2, b1, b0};

        read_word = raw_word;
        if (!owner_fetch && load_signed_q) begin
            case (cur_size)
                3'd1:    read_word = {{24{raw_word[7]}},  raw_word[7:0]};
                3'd2:    read_word = {{16{raw_word[15]}}, raw_word[15:0]};
                default: read_word = raw_word;
            endcase
        end

        // Only the write strobe is gated combinationally: by rdy and by the I/O stall.
        mem_wr = mem_wr_q && rdy && !io_stall;
    end

    // ---------------- request latches ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pend    <= 1'b0;
            load_pend     <= 1'b0;
            store_pend    <= 1'b0;
            fetch_addr_q  <= '0;
            load_addr_q   <= '0;
            store_addr_q  <= '0;
            load_size_q   <= 3'd0;
            store_size_q  <= 3'd0;
            load_signed_q <= 1'b0;
            store_data_q  <= 32'h0;
        end else if (rdy) begin
            if (in_store_ce) begin
                store_pend   <= 1'b1;
                store_addr_q <= in_store_addr;
                store_size_q <= in_store_size;
                store_data_q <= in_store_data;
            end else if (write_done) begin
                store_pend   <= 1'b0;
            end

            if (in_clear) begin
                load_pend     <= 1'b0;
            end else if (in_load_ce) begin
                load_pend     <= 1'b1;
                load_addr_q   <= in_load_addr;
                load_size_q   <= in_load_size;
                load_signed_q <= in_load_signed;
            end else if (read_done && !owner_fetch) begin
                load_pend     <= 1'b0;
            end

            if (in_clear) begin
                fetch_pend   <= 1'b0;
            end else if (in_fetch_ce) begin
                fetch_pend   <= 1'b1;
                fetch_addr_q <= in_fetch_addr;
            end else if (read_done && owner_fetch) begin
                fetch_pend   <= 1'b0;
            end
        end
    end

    // ---------------- registered outputs and byte engine ----------------
    // NOTE: the small read byte buffer is reset along with everything else so the
    // bus outputs are deterministic from reset; it is not a RAM array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= 2'd0;
            cur_size       <= 3'd0;
            owner_fetch    <= 1'b0;
            rbuf           <= '0;
            mem_wr_q       <= 1'b0;
            mem_a          <= '0;
            mem_dout       <= 8'h00;
            out_fetch_ce   <= 1'b0;
            out_fetch_data <= 32'h0;
            out_load_ce    <= 1'b0;
            out_load_data  <= 32'h0;
            out_store_ce   <= 1'b0;
        end else if (rdy) begin
            out_fetch_ce <= 1'b0;
            out_load_ce  <= 1'b0;
            out_store_ce <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    if (grant_store) begin
                        mem_a    <= store_addr_q;
                        mem_dout <= store_data_q[7:0];
                        mem_wr_q <= 1'b1;
                        cur_size <= store_size_q;
                    end else if (grant_load) begin
                        mem_a       <= load_addr_q;
                        cur_size    <= load_size_q;
                        owner_fetch <= 1'b0;
                    end else if (grant_fetch) begin
                        mem_a       <= fetch_addr_q;
                        cur_size    <= 3'd4;
                        owner_fetch <= 1'b1;
                    end
                end
                READ: begin
                    if (in_clear) begin
                        cnt <= 2'd0;
                    end else if (last_byte) begin
                        cnt <= 2'd0;
                        if (owner_fetch) begin
                            out_fetch_ce   <= 1'b1;
                            out_fetch_data <= read_word;
                        end else begin
                            out_load_ce    <= 1'b1;
                            out_load_data  <= read_word;
                        end
                    end else begin
                        rbuf[cnt] <= mem_din;
                        cnt       <= cnt_next;
                        mem_a     <= mem_a + ADDR_W'(1);
                    end
                end
                WRITE: begin
                    // During an I/O stall the byte, address and counter all hold.
                    if (!io_stall) begin
                        if (last_byte) begin
                            cnt          <= 2'd0;
                            mem_wr_q     <= 1'b0;
                            out_store_ce <= 1'b1;
                        end else begin
                            cnt      <= cnt_next;
                            mem_a    <= mem_a + ADDR_W'(1);
                            mem_dout <= store_data_q[8*cnt_next +: 8];
                        end
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl. Cycle k is the clock period that
// starts at the k-th rising edge after a request pulse is sampled (edge 0).
// Inputs change and outputs are sampled on the falling edge, mid-cycle.
// The RAM model returns the byte of the currently driven address within the
// cycle, so byte k addressed in cycle 1+k is captured at edge 2+k.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, in_clear;
    logic        in_fetch_ce;
    logic [31:0] in_fetch_addr;
    logic        out_fetch_ce;
    logic [31:0] out_fetch_data;
    logic        in_load_ce;
    logic [31:0] in_load_addr;
    logic [2:0]  in_load_size;
    logic        in_load_signed;
    logic        out_load_ce;
    logic [31:0] out_load_data;
    logic        in_store_ce;
    logic [31:0] in_store_addr;
    logic [2:0]  in_store_size;
    logic [31:0] in_store_data;
    logic        out_store_ce;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:1023];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] sw_word;
    logic        seen;

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[9:0]];

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_clear       (in_clear),
        .in_fetch_ce    (in_fetch_ce),
        .in_fetch_addr  (in_fetch_addr),
        .out_fetch_ce   (out_fetch_ce),
        .out_fetch_data (out_fetch_data),
        .in_load_ce     (in_load_ce),
        .in_load_addr   (in_load_addr),
        .in_load_size   (in_load_size),
        .in_load_signed (in_load_signed),
        .out_load_ce    (out_load_ce),
        .out_load_data  (out_load_data),
        .in_store_ce    (in_store_ce),
        .in_store_addr  (in_store_addr),
        .in_store_size  (in_store_size),
        .in_store_data  (in_store_data),
        .out_store_ce   (out_store_ce),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue a load, then check no done in cycle n and done + data in cycle n+1.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                           input logic sgn, input logic [31:0] exp);
        in_load_ce     = 1'b1;
        in_load_addr   = addr;
        in_load_size   = size;
        in_load_signed = sgn;
        @(negedge clk);
        in_load_ce = 1'b0;
        repeat (int'(size)) @(negedge clk);
        check({tag, "_early"}, {31'b0, out_load_ce}, 32'd0);
        @(negedge clk);
        check({tag, "_done"}, {31'b0, out_load_ce}, 32'd1);
        check({tag, "_data"}, out_load_data, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, out_load_ce}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h104] = 8'h80; ram[10'h106] = 8'h01; ram[10'h107] = 8'h80;

        rst = 1'b1; rdy = 1'b1; in_clear = 1'b0;
        in_fetch_ce = 1'b0; in_fetch_addr = '0;
        in_load_ce = 1'b0; in_load_addr = '0; in_load_size = 3'd0; in_load_signed = 1'b0;
        in_store_ce = 1'b0; in_store_addr = '0; in_store_size = 3'd0; in_store_data = '0;
        io_buffer_full = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_done", {29'b0, out_fetch_ce, out_load_ce, out_store_ce}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LW 0x100: address trace 0x100..0x103 in cycles 1..4, done in cycle 5.
        in_load_ce = 1'b1; in_load_addr = 32'h100; in_load_size = 3'd4; in_load_signed = 1'b0;
        @(negedge clk);
        in_load_ce = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("lw_addr_c%0d", c), mem_a, 32'h100 + 32'(c - 1));
            check($sformatf("lw_nodone_c%0d", c), {31'b0, out_load_ce}, 32'd0);
        end
        @(negedge clk);
        check("lw_done", {31'b0, out_load_ce}, 32'd1);
        check("lw_data", out_load_data, 32'h44332211);
        @(negedge clk);
        check("lw_pulse", {31'b0, out_load_ce}, 32'd0);
        @(negedge clk);

        // Byte / halfword extension.
        do_load("lb",   32'h104, 3'd1, 1'b1, 32'hFFFFFF80);
        do_load("lbu",  32'h104, 3'd1, 1'b0, 32'h00000080);
        do_load("lh",   32'h106, 3'd2, 1'b1, 32'hFFFF8001);
        do_load("lhu",  32'h106, 3'd2, 1'b0, 32'h00008001);

        // Fetch and SW in the same cycle: store wins, fetch granted at edge 6.
        sw_word = 32'hAABBCCDD;
        in_fetch_ce = 1'b1; in_fetch_addr = 32'h100;
        in_store_ce = 1'b1; in_store_addr = 32'h200; in_store_size = 3'd4; in_store_data = sw_word;
        @(negedge clk);
        in_fetch_ce = 1'b0; in_store_ce = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("sw_wr_c%0d", c), {31'b0, mem_wr}, 32'd1);
            check($sformatf("sw_addr_c%0d", c), mem_a, 32'h200 + 32'(c - 1));
            check($sformatf("sw_byte_c%0d", c), {24'b0, mem_dout}, {24'b0, sw_word[8*(c-1) +: 8]});
        end
        @(negedge clk);
        check("sw_done", {31'b0, out_store_ce}, 32'd1);
        check("sw_wr_off", {31'b0, mem_wr}, 32'd0);
        check("fetch_wait", mem_a, 32'h203);
        @(negedge clk);
        check("fetch_grant_addr", mem_a, 32'h100);
        check("sw_pulse", {31'b0, out_store_ce}, 32'd0);
        repeat (3) @(negedge clk);
        check("fetch_early", {31'b0, out_fetch_ce}, 32'd0);
        @(negedge clk);
        check("fetch_done", {31'b0, out_fetch_ce}, 32'd1);
        check("fetch_data", out_fetch_data, 32'h44332211);
        repeat (2) @(negedge clk);

        // SB 0x41 into the I/O region while the UART buffer is full for 3 cycles.
        in_store_ce = 1'b1; in_store_addr = 32'h00030000; in_store_size = 3'd1; in_store_data = 32'h41;
        io_buffer_full = 1'b1;
        @(negedge clk);
        in_store_ce = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("io_stall_c%0d", c), {31'b0, mem_wr}, 32'd0);
        end
        @(posedge clk);
        #1 io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_wr", {31'b0, mem_wr}, 32'd1);
        check("io_addr", mem_a, 32'h00030000);
        check("io_byte", {24'b0, mem_dout}, 32'h41);
        check("io_nodone", {31'b0, out_store_ce}, 32'd0);
        @(negedge clk);
        check("io_done", {31'b0, out_store_ce}, 32'd1);
        check("io_wr_off", {31'b0, mem_wr}, 32'd0);
        repeat (2) @(negedge clk);

        // Clear during an LW with a store pending: load dropped, SH 0xBEEF proceeds.
        seen = 1'b0;
        in_load_ce = 1'b1; in_load_addr = 32'h100; in_load_size = 3'd4; in_load_signed = 1'b0;
        @(negedge clk);
        in_load_ce = 1'b0;
        in_store_ce = 1'b1; in_store_addr = 32'h210; in_store_size = 3'd2; in_store_data = 32'h0000BEEF;
        @(negedge clk);
        in_store_ce = 1'b0;
        check("clr_rd_addr", mem_a, 32'h100);
        @(negedge clk);
        in_clear = 1'b1;
        @(negedge clk);
        in_clear = 1'b0;
        seen = seen | out_load_ce;
        check("clr_no_wr", {31'b0, mem_wr}, 32'd0);
        @(negedge clk);
        seen = seen | out_load_ce;
        check("clr_sh_wr0", {31'b0, mem_wr}, 32'd1);
        check("clr_sh_a0", mem_a, 32'h210);
        check("clr_sh_b0", {24'b0, mem_dout}, 32'hEF);
        @(negedge clk);
        seen = seen | out_load_ce;
        check("clr_sh_a1", mem_a, 32'h211);
        check("clr_sh_b1", {24'b0, mem_dout}, 32'hBE);
        @(negedge clk);
        seen = seen | out_load_ce;
        check("clr_sh_done", {31'b0, out_store_ce}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_load_ce;
        end
        check("clr_no_load_done", {31'b0, seen}, 32'd0);

        // rdy gating, then asynchronous reset in the middle of a SW.
        in_store_ce = 1'b1; in_store_addr = 32'h200; in_store_size = 3'd4; in_store_data = sw_word;
        @(negedge clk);
        in_store_ce = 1'b0;
        @(negedge clk);
        check("rdy_wr_on", {31'b0, mem_wr}, 32'd1);
        #1 rdy = 1'b0;
        #1 check("rdy_wr_gated", {31'b0, mem_wr}, 32'd0);
        @(negedge clk);
        check("rdy_freeze_a", mem_a, 32'h200);
        check("rdy_freeze_b", {24'b0, mem_dout}, 32'hDD);
        rdy = 1'b1;
        #1 check("rdy_wr_back", {31'b0, mem_wr}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_wr", {31'b0, mem_wr}, 32'd0);
        check("arst_a", mem_a, 32'd0);
        check("arst_dout", {24'b0, mem_dout}, 32'd0);
        check("arst_done", {29'b0, out_fetch_ce, out_load_ce, out_store_ce}, 32'd0);
        check("arst_ldata", out_load_data, 32'd0);
        check("arst_fdata", out_fetch_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | mem_wr | out_store_ce;
        end
        check("arst_store_dropped", {31'b0, seen}, 32'd0);
        do_load("post_rst_lbu", 32'h104, 3'd1, 1'b0, 32'h00000080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
